// File: rtl/fft_stage_sched_if.sv
// Control and address bus between the FFT top-level controller and the stage scheduler.
// bf_valid and wr_en are single-cycle strobes with no back-pressure; the RAM and butterfly pipe
// must accept every strobe in the cycle it appears.
interface fft_stage_sched_if #(parameter int N = 3);
  logic         start;
  logic         abort;
  logic         busy;
  logic         done;
  logic [1:0]   stage;
  logic         bf_valid;
  logic [N-1:0] rd_addr_a;
  logic [N-1:0] rd_addr_b;
  logic [N-2:0] twid_idx;
  logic         shift_en;
  logic         wr_en;
  logic [N-1:0] wr_addr_a;
  logic [N-1:0] wr_addr_b;
  logic [1:0]   state_dbg;

  modport master (
    output start, abort,
    input  busy, done, stage, bf_valid, rd_addr_a, rd_addr_b, twid_idx,
           shift_en, wr_en, wr_addr_a, wr_addr_b, state_dbg
  );

  modport slave (
    input  start, abort,
    output busy, done, stage, bf_valid, rd_addr_a, rd_addr_b, twid_idx,
           shift_en, wr_en, wr_addr_a, wr_addr_b, state_dbg
  );
endinterface

// File: rtl/fft_stage_sched.sv
// Radix-2 DIT FFT stage/butterfly sequencer: issues N x 2**(N-1) butterflies with drain gaps
// between stages and a BF_LAT-deep write-back delay line.
module fft_stage_sched #(
    parameter int N        = 3,
    parameter int BF_LAT   = 2,
    parameter bit SCALE_EN = 1'b1
) (
    input logic               clk,
    input logic               rst_n,
    fft_stage_sched_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    localparam int              KW         = N - 1;
    localparam logic [KW-1:0]   K_LAST     = '1;
    localparam logic [2:0]      DRAIN_LAST = 3'(BF_LAT - 1);
    localparam logic [1:0]      STAGE_LAST = 2'(N - 1);

    state_t        state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [1:0]    stage_q, stage_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          bf_valid_q, bf_valid_d;
    logic          shift_en_q, shift_en_d;
    logic [N-1:0]  rd_a_q, rd_a_d;
    logic [N-1:0]  rd_b_q, rd_b_d;
    logic [KW-1:0] twid_q, twid_d;

    logic [BF_LAT-1:0] dl_v_q, dl_v_d;
    logic [N-1:0]      dl_a_q [BF_LAT];
    logic [N-1:0]      dl_a_d [BF_LAT];
    logic [N-1:0]      dl_b_q [BF_LAT];
    logic [N-1:0]      dl_b_d [BF_LAT];

    logic [N-1:0] k_ext, span, grp, pos, addr_a;
    logic         issue;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        stage_d = stage_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_ISSUE;
                    k_d     = '0;
                    stage_d = '0;
                end
            end
            S_ISSUE: begin
                if (k_q == K_LAST) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            S_DRAIN: begin
                // The gap lets the last write-back of this stage land before the next stage reads.
                if (cnt_q == DRAIN_LAST) begin
                    if (stage_q == STAGE_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ISSUE;
                        stage_d = stage_q + 2'd1;
                        k_d     = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (bus.abort) begin
            state_d = S_IDLE;
        end
    end

    // Outputs are computed from the next-state values so that every port is a plain flop.
    always_comb begin
        issue      = (state_d == S_ISSUE);
        k_ext      = N'(k_d);
        span       = N'(1) << stage_d;
        grp        = k_ext >> stage_d;
        pos        = k_ext & (span - N'(1));
        addr_a     = (grp << ({1'b0, stage_d} + 3'd1)) | pos;
        bf_valid_d = issue;
        shift_en_d = issue & SCALE_EN;
        rd_a_d     = issue ? addr_a : '0;
        rd_b_d     = issue ? (addr_a + span) : '0;
        twid_d     = issue ? KW'(pos << (3'(KW) - {1'b0, stage_d})) : '0;
        busy_d     = issue | (state_d == S_DRAIN);
        done_d     = (state_d == S_DONE);
    end

    always_comb begin
        dl_v_d    = '0;
        dl_a_d[0] = rd_a_q;
        dl_b_d[0] = rd_b_q;
        dl_v_d[0] = bf_valid_q;
        for (int i = 1; i < BF_LAT; i++) begin
            dl_v_d[i] = dl_v_q[i-1];
            dl_a_d[i] = dl_a_q[i-1];
            dl_b_d[i] = dl_b_q[i-1];
        end
        if (bus.abort) begin
            for (int i = 0; i < BF_LAT; i++) begin
                dl_v_d[i] = 1'b0;
                dl_a_d[i] = '0;
                dl_b_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            k_q        <= '0;
            cnt_q      <= '0;
            stage_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            bf_valid_q <= 1'b0;
            shift_en_q <= 1'b0;
            rd_a_q     <= '0;
            rd_b_q     <= '0;
            twid_q     <= '0;
            dl_v_q     <= '0;
            for (int i = 0; i < BF_LAT; i++) begin
                dl_a_q[i] <= '0;
                dl_b_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            cnt_q      <= cnt_d;
            stage_q    <= stage_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            bf_valid_q <= bf_valid_d;
            shift_en_q <= shift_en_d;
            rd_a_q     <= rd_a_d;
            rd_b_q     <= rd_b_d;
            twid_q     <= twid_d;
            dl_v_q     <= dl_v_d;
            for (int i = 0; i < BF_LAT; i++) begin
                dl_a_q[i] <= dl_a_d[i];
                dl_b_q[i] <= dl_b_d[i];
            end
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.stage     = stage_q;
    assign bus.bf_valid  = bf_valid_q;
    assign bus.rd_addr_a = rd_a_q;
    assign bus.rd_addr_b = rd_b_q;
    assign bus.twid_idx  = twid_q;
    assign bus.shift_en  = shift_en_q;
    assign bus.wr_en     = dl_v_q[BF_LAT-1];
    assign bus.wr_addr_a = dl_a_q[BF_LAT-1];
    assign bus.wr_addr_b = dl_b_q[BF_LAT-1];
    assign bus.state_dbg = state_q;
endmodule
